// File: rtl/ovr_i_mgr_if.sv
// Bundle between the PWM generators, the driver over-current flags
// and the over-current manager.
interface ovr_i_mgr_if;
    logic       PWM_synch;
    logic       ovr_I_blank;
    logic       OVR_I_lft;
    logic       OVR_I_rght;
    logic       clr_fault;
    logic       PWM_en;
    logic       fault;
    logic       fault_lft;
    logic       fault_rght;
    logic [3:0] ovr_cnt;

    modport master (
        output PWM_synch, ovr_I_blank, OVR_I_lft, OVR_I_rght, clr_fault,
        input  PWM_en, fault, fault_lft, fault_rght, ovr_cnt
    );

    modport slave (
        input  PWM_synch, ovr_I_blank, OVR_I_lft, OVR_I_rght, clr_fault,
        output PWM_en, fault, fault_lft, fault_rght, ovr_cnt
    );
endinterface

// File: rtl/ovr_i_mgr.sv
// Over-current fault manager: counts faulty PWM periods, latches a fault,
// and re-arms after a minimum off time plus an explicit clear.
module ovr_i_mgr #(
    parameter int FAULT_PERIODS = 3,
    parameter int MIN_OFF       = 4096
) (
    input  logic          clk,
    input  logic          rst,
    ovr_i_mgr_if.slave    bus
);
    localparam logic [15:0] OFF_MAX  = 16'(MIN_OFF - 1);
    localparam logic [3:0]  TRIP_CNT = 4'(FAULT_PERIODS);

    typedef enum logic [1:0] {
        REARM = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q;
    logic        pwm_en_q;
    logic        fault_q;
    logic        fault_lft_q;
    logic        fault_rght_q;
    logic [3:0]  ovr_cnt_q;
    logic        evt_lft_q;
    logic        evt_rght_q;
    logic [15:0] off_cnt_q;
    logic        lft_s1_q;
    logic        lft_s2_q;
    logic        rght_s1_q;
    logic        rght_s2_q;

    logic        cur_lft_d;
    logic        cur_rght_d;
    logic        period_bad_d;
    logic [3:0]  ovr_cnt_d;
    logic        trip_d;
    logic        off_sat_d;

    // Blanking is already clk-synchronous, so it gates the synced flags directly.
    assign cur_lft_d    = lft_s2_q & ~bus.ovr_I_blank;
    assign cur_rght_d   = rght_s2_q & ~bus.ovr_I_blank;
    assign period_bad_d = evt_lft_q | evt_rght_q;
    assign ovr_cnt_d    = (ovr_cnt_q == 4'hF) ? 4'hF : ovr_cnt_q + 4'd1;
    assign trip_d       = period_bad_d && (ovr_cnt_d >= TRIP_CNT);
    assign off_sat_d    = (off_cnt_q == OFF_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REARM;
            pwm_en_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_lft_q  <= 1'b0;
            fault_rght_q <= 1'b0;
            ovr_cnt_q    <= 4'd0;
            evt_lft_q    <= 1'b0;
            evt_rght_q   <= 1'b0;
            off_cnt_q    <= 16'd0;
            lft_s1_q     <= 1'b0;
            lft_s2_q     <= 1'b0;
            rght_s1_q    <= 1'b0;
            rght_s2_q    <= 1'b0;
        end else begin
            lft_s1_q  <= bus.OVR_I_lft;
            lft_s2_q  <= lft_s1_q;
            rght_s1_q <= bus.OVR_I_rght;
            rght_s2_q <= rght_s1_q;

            unique case (state_q)
                REARM: begin
                    if (bus.PWM_synch) begin
                        state_q    <= RUN;
                        pwm_en_q   <= 1'b1;
                        ovr_cnt_q  <= 4'd0;
                        evt_lft_q  <= 1'b0;
                        evt_rght_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.PWM_synch) begin
                        ovr_cnt_q <= period_bad_d ? ovr_cnt_d : 4'd0;
                        if (trip_d) begin
                            state_q      <= FAULT;
                            pwm_en_q     <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_lft_q  <= evt_lft_q;
                            fault_rght_q <= evt_rght_q;
                            evt_lft_q    <= 1'b0;
                            evt_rght_q   <= 1'b0;
                            off_cnt_q    <= 16'd0;
                        end else begin
                            // An event in the synch cycle opens the new period.
                            evt_lft_q  <= cur_lft_d;
                            evt_rght_q <= cur_rght_d;
                        end
                    end else begin
                        evt_lft_q  <= evt_lft_q | cur_lft_d;
                        evt_rght_q <= evt_rght_q | cur_rght_d;
                    end
                end
                FAULT: begin
                    if (bus.clr_fault && off_sat_d) begin
                        state_q      <= REARM;
                        fault_q      <= 1'b0;
                        fault_lft_q  <= 1'b0;
                        fault_rght_q <= 1'b0;
                        ovr_cnt_q    <= 4'd0;
                        off_cnt_q    <= 16'd0;
                    end else if (!off_sat_d) begin
                        off_cnt_q <= off_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q  <= REARM;
                    pwm_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PWM_en     = pwm_en_q;
    assign bus.fault      = fault_q;
    assign bus.fault_lft  = fault_lft_q;
    assign bus.fault_rght = fault_rght_q;
    assign bus.ovr_cnt    = ovr_cnt_q;
endmodule
